// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access size codes,
// FSM states and the wait-counter width.
package dmem_responder_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/dmem_responder_ld_ext.sv
// Load lane extraction: picks the addressed byte/halfword out of a stored
// word and sign- or zero-extends it to 32 bits.
module mem_ld_ext
    import dmem_responder_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_addr)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

        // Reserved size code behaves as a full word.
        case (i_size)
            SZ_BYTE: o_result = {{24{i_sign & w_byte[7]}}, w_byte};
            SZ_HALF: o_result = {{16{i_sign & w_half[15]}}, w_half};
            default: o_result = i_word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for a stalling CPU memory stage:
// word-wide storage with byte lanes, programmable wait states, alignment traps.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        adel,
    output logic        ades
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t              r_state;
    logic [WAIT_W-1:0]   r_count;
    logic [31:0]         r_rdata;
    logic [31:0]         r_mem [DEPTH_WORDS];

    state_t              w_nextState;
    logic [WAIT_W-1:0]   w_nextCount;
    logic                w_access;
    logic                w_misaligned;
    logic [AW-1:0]       w_index;
    logic [3:0]          w_laneEn;
    logic [31:0]         w_wdataLanes;
    logic [31:0]         w_loadResult;
    logic                w_unusedAddrHigh;

    // Upper address bits alias onto the same storage.
    assign w_index          = addr[AW+1:2];
    assign w_unusedAddrHigh = ^addr[31:AW+2];

    assign w_misaligned = ((size == SZ_HALF) && addr[0]) ||
                          (size[1] && (addr[1:0] != 2'b00));

    always_comb begin
        w_laneEn     = 4'b1111;
        w_wdataLanes = wdata;
        case (size)
            SZ_BYTE: begin
                w_laneEn     = 4'b0001 << addr[1:0];
                w_wdataLanes = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                w_laneEn     = addr[1] ? 4'b1100 : 4'b0011;
                w_wdataLanes = {2{wdata[15:0]}};
            end
            default: begin
                w_laneEn     = 4'b1111;
                w_wdataLanes = wdata;
            end
        endcase
    end

    mem_ld_ext u_ld_ext (
        .i_word   (r_mem[w_index]),
        .i_addr   (addr[1:0]),
        .i_size   (size),
        .i_sign   (sign),
        .o_result (w_loadResult)
    );

    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_access    = 1'b0;
        stall       = 1'b0;
        adel        = 1'b0;
        ades        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    if (w_misaligned) begin
                        adel = ~we;
                        ades = we;
                    end else begin
                        stall       = 1'b1;
                        w_nextState = ST_BUSY;
                        w_nextCount = WAIT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_BUSY: begin
                // Dropping req here is a pipeline flush: abandon the access.
                if (req) begin
                    stall = 1'b1;
                    if (r_count != '0) begin
                        w_nextCount = r_count - 1'b1;
                    end else begin
                        w_access    = 1'b1;
                        w_nextState = ST_DONE;
                    end
                end else begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_DONE: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_rdata <= 32'h0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            if (w_access && !we) begin
                r_rdata <= w_loadResult;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_access && we && !rst) begin
            for (int k = 0; k < 4; k++) begin
                if (w_laneEn[k]) begin
                    r_mem[w_index][8*k +: 8] <= w_wdataLanes[8*k +: 8];
                end
            end
        end
    end

    assign rdata = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (1 and 3 wait states)
// driven with directed accesses whose results are computed by hand.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic              clk = 1'b0;
    logic [1:0]        rst;
    logic [1:0]        req;
    logic              we;
    logic [1:0]        size;
    logic              sign;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [1:0][31:0]  rdataV;
    logic [1:0]        stall;
    logic [1:0]        adel;
    logic [1:0]        ades;

    int                assertCount = 0;
    int                failCount   = 0;
    logic [31:0]       expQ0[$];
    logic [31:0]       expQ1[$];
    logic [31:0]       lastRd [2];
    int                stallRun [2];
    logic              prevStall [2];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst[0]), .req(req[0]), .we(we), .size(size),
        .sign(sign), .addr(addr), .wdata(wdata), .rdata(rdataV[0]),
        .stall(stall[0]), .adel(adel[0]), .ades(ades[0])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst[1]), .req(req[1]), .we(we), .size(size),
        .sign(sign), .addr(addr), .wdata(wdata), .rdata(rdataV[1]),
        .stall(stall[1]), .adel(adel[1]), .ades(ades[1])
    );

    function automatic int waitOf(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // A completion is the cycle where stall falls while req is still held.
    task automatic monitorOne(input int k);
        logic [31:0] exp;
        if (rst[k]) begin
            stallRun[k]  = 0;
            prevStall[k] = 1'b0;
        end else if (stall[k]) begin
            stallRun[k]++;
            prevStall[k] = 1'b1;
        end else begin
            if (prevStall[k] && req[k]) begin
                checkOutput($sformatf("stall_len%0d", k), 32'(stallRun[k]),
                            32'(waitOf(k) + 1));
                if ((k == 0 ? expQ0.size() : expQ1.size()) == 0) begin
                    checkOutput($sformatf("unexpected_done%0d", k), 32'd1, 32'd0);
                end else begin
                    exp = (k == 0) ? expQ0.pop_front() : expQ1.pop_front();
                    checkOutput($sformatf("rdata%0d", k), rdataV[k], exp);
                end
            end
            stallRun[k]  = 0;
            prevStall[k] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        monitorOne(0);
        monitorOne(1);
    end

    // Full access: expLoad is the load result; stores expect rdata unchanged.
    task automatic applyStimulus(input int k, input logic iWe,
                                 input logic [1:0] iSize, input logic iSign,
                                 input logic [31:0] iAddr, input logic [31:0] iWdata,
                                 input logic [31:0] expLoad);
        logic [31:0] exp;
        bit          done;
        @(posedge clk);
        #1;
        we = iWe; size = iSize; sign = iSign; addr = iAddr; wdata = iWdata;
        exp = iWe ? lastRd[k] : expLoad;
        lastRd[k] = exp;
        if (k == 0) expQ0.push_back(exp);
        else        expQ1.push_back(exp);
        req[k] = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!stall[k]) done = 1'b1;
        end
        if (!done) checkOutput("access_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        req[k] = 1'b0;
    endtask

    task automatic checkMisaligned(input int k, input logic iWe,
                                   input logic [1:0] iSize, input logic [31:0] iAddr,
                                   input logic [31:0] iWdata);
        @(posedge clk);
        #1;
        we = iWe; size = iSize; sign = 1'b0; addr = iAddr; wdata = iWdata;
        req[k] = 1'b1;
        #1;
        checkOutput("mis_adel", 32'(adel[k]), 32'(!iWe));
        checkOutput("mis_ades", 32'(ades[k]), 32'(iWe));
        checkOutput("mis_stall", 32'(stall[k]), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("mis_still_idle", 32'(adel[k] | ades[k]), 32'd1);
        req[k] = 1'b0;
        #1;
        checkOutput("mis_noreq_flags", 32'({adel[k], ades[k]}), 32'd0);
    endtask

    initial begin
        rst = 2'b11; req = 2'b00; we = 1'b0; size = SZ_WORD; sign = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        lastRd[0] = 32'h0; lastRd[1] = 32'h0;
        stallRun[0] = 0; stallRun[1] = 0;
        prevStall[0] = 1'b0; prevStall[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 2'b00;
        #1;
        for (int k = 0; k < 2; k++) begin
            checkOutput("reset_rdata", rdataV[k], 32'h0);
            checkOutput("reset_stall", 32'(stall[k]), 32'd0);
            checkOutput("reset_adel", 32'(adel[k]), 32'd0);
            checkOutput("reset_ades", 32'(ades[k]), 32'd0);
        end

        // One wait state: word, byte and halfword traffic around 0x10.
        applyStimulus(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0);
        applyStimulus(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
        applyStimulus(0, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 32'hFFFFFFDE);
        applyStimulus(0, 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 32'h000000DE);
        applyStimulus(0, 1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, 32'hFFFFBEEF);
        applyStimulus(0, 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h000000AA, 32'h0);
        applyStimulus(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADAAEF);
        applyStimulus(0, 1'b1, SZ_HALF, 1'b0, 32'h12, 32'h00001234, 32'h0);
        applyStimulus(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h1234AAEF);
        applyStimulus(0, 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 32'h00001234);
        applyStimulus(0, 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, 32'hFFFFFFAA);
        applyStimulus(0, 1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0, 32'h000000EF);
        applyStimulus(0, 1'b0, SZ_WORD, 1'b1, 32'h1010, 32'h0, 32'h1234AAEF);
        applyStimulus(0, 1'b0, 2'b11,   1'b1, 32'h10, 32'h0, 32'h1234AAEF);

        // Misaligned accesses leave storage and FSM untouched.
        applyStimulus(0, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h0BADF00D, 32'h0);
        checkMisaligned(0, 1'b0, SZ_HALF, 32'h21, 32'h0);
        checkMisaligned(0, 1'b1, SZ_WORD, 32'h22, 32'hFFFFFFFF);
        applyStimulus(0, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h0BADF00D);

        // Three wait states: flush and reset both abort a pending store.
        applyStimulus(1, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'h11223344, 32'h0);
        applyStimulus(1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 32'h11223344);
        applyStimulus(1, 1'b0, SZ_BYTE, 1'b1, 32'h42, 32'h0, 32'h00000022);

        @(posedge clk);
        #1;
        we = 1'b1; size = SZ_WORD; addr = 32'h40; wdata = 32'hCAFEF00D;
        req[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        req[1] = 1'b0;
        #1;
        checkOutput("flush_stall", 32'(stall[1]), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("flush_rdata", rdataV[1], 32'h00000022);
        applyStimulus(1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 32'h11223344);

        @(posedge clk);
        #1;
        we = 1'b1; size = SZ_WORD; addr = 32'h40; wdata = 32'h55555555;
        req[1] = 1'b1;
        @(posedge clk);
        #1;
        rst[1] = 1'b1;
        req[1] = 1'b0;
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        checkOutput("busy_reset_rdata", rdataV[1], 32'h0);
        lastRd[1] = 32'h0;
        applyStimulus(1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 32'h11223344);

        repeat (5) @(posedge clk);
        checkOutput("queue0_drained", 32'(expQ0.size()), 32'd0);
        checkOutput("queue1_drained", 32'(expQ1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, meaning words of storage; word index = addr[log2(DEPTH_WORDS)+1:2], upper address bits ignored (aliasing).
REQ-002 Parameter WAIT_CYCLES, default 1, meaning added access wait states; legal range 1..15.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req  input  1  memory-stage access request, held by the CPU while stall is high.
REQ-007 we  input  1  1 = store, 0 = load.
REQ-008 size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
REQ-009 sign  input  1  load extension: 1 sign-extend, 0 zero-extend.
REQ-010 addr  input  32  byte address.
REQ-011 wdata  input  32  store data, right-justified.
REQ-012 rdata  output  32  load result, right-justified and extended.
REQ-013 stall  output  1  combinational; high freezes the CPU pipeline.
REQ-014 adel  output  1  combinational; misaligned load flag.
REQ-015 ades  output  1  combinational; misaligned store flag.

Function
REQ-016 FSM states IDLE, BUSY, DONE; a wait counter of 4 bits.
REQ-017 Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-018 IDLE, req=1, misaligned: adel=~we, ades=we, stall=0, state stays IDLE, no storage change.
REQ-019 IDLE, req=1, aligned: stall=1, next state BUSY, counter loaded WAIT_CYCLES-1.
REQ-020 BUSY, req=1: stall=1; counter!=0 -> decrement; counter=0 -> perform access at that edge, next state DONE.
REQ-021 Access is performed exactly once per request, at the BUSY->DONE edge; stall is high for exactly WAIT_CYCLES+1 cycles.
REQ-022 DONE: stall=0, rdata holds the registered load result; next state IDLE unconditionally.
REQ-023 BUSY with req=0 (pipeline flush): abort to IDLE, no storage write, rdata unchanged.
REQ-024 A new request is accepted only in IDLE; back-to-back accesses therefore have one IDLE cycle between DONE and the next BUSY.
REQ-025 Byte lanes little-endian: lane k = bits [8k+7:8k] selected by addr[1:0]=k.
REQ-026 Store byte writes only lane addr[1:0] with wdata[7:0]; halfword writes lanes addr[1]*2 and addr[1]*2+1 with wdata[15:0]; word writes all lanes.
REQ-027 Load byte/halfword extracts the addressed lane(s), then sign- or zero-extends to 32 bits per sign; word load ignores sign.
REQ-028 Store completion leaves rdata unchanged.
REQ-029 adel/ades are 0 whenever req=0 or state!=IDLE.

Reset
REQ-030 On rst: state IDLE, counter 0, rdata 32'h0; stall, adel, ades 0 after the reset edge given req=0.
REQ-031 Reset in BUSY aborts the access; no write occurs at that edge.
REQ-032 Storage contents are not cleared by reset.

Structure
REQ-033 Shared package holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-034 One sub-module, mem_ld_ext: combinational lane extraction and extension (inputs word, addr[1:0], size, sign; output 32-bit result).
REQ-035 Storage is a single word-wide array with per-lane write enables.

Verification
REQ-036 WAIT_CYCLES=1, store word 32'hDEADBEEF at 0x10, then load word 0x10 -> stall high 2 cycles each, rdata=32'hDEADBEEF in DONE.
REQ-037 After REQ-036, load byte 0x13 sign=1 -> 32'hFFFFFFDE; sign=0 -> 32'h000000DE; load half 0x10 sign=1 -> 32'hFFFFBEEF.
REQ-038 Store byte 32'h000000AA at 0x11, load word 0x10 -> 32'hDEADAAEF; store half 32'h1234 at 0x12 -> word 32'h1234AAEF.
REQ-039 Load half at 0x21 -> adel=1, stall=0, no FSM transition; store word at 0x22 -> ades=1, storage unchanged.
REQ-040 WAIT_CYCLES=3, store word at 0x40, drop req in the second BUSY cycle -> return to IDLE, subsequent load of 0x40 returns prior contents; assert rst during BUSY -> no write, rdata=0.
